// File: rtl/regfile_bist_if.sv
// Register-file port bundle between the BIST initiator (master) and the
// register file (slave): one write port and two read ports.
interface regfile_bist_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              rf_writeEn;
  logic [ADDR_W-1:0] rf_writeReg;
  logic [DATA_W-1:0] rf_writeData;
  logic [ADDR_W-1:0] rf_readRegA;
  logic [ADDR_W-1:0] rf_readRegB;
  logic [DATA_W-1:0] rf_readDataA;
  logic [DATA_W-1:0] rf_readDataB;

  modport master (
    output rf_writeEn,
    output rf_writeReg,
    output rf_writeData,
    output rf_readRegA,
    output rf_readRegB,
    input  rf_readDataA,
    input  rf_readDataB
  );

  modport slave (
    input  rf_writeEn,
    input  rf_writeReg,
    input  rf_writeData,
    input  rf_readRegA,
    input  rf_readRegB,
    output rf_readDataA,
    output rf_readDataB
  );
endinterface

// File: rtl/regfile_bist.sv
// regfile_bist: built-in self-test initiator for the register file.
// Walks every register: write the test word, read it back on ports A and B,
// compare against the expected value (register 0 always reads zero), count
// mismatches (saturating) and latch the first failing address/port.
// Optional feature macro: REGFILE_BIST_INV_PASS_EN -- when defined, a second
// pass over all registers runs with the inverted test word.
module regfile_bist #(
  parameter int                 NUM_REGS = 32,
  parameter int                 ADDR_W   = 5,
  parameter int                 DATA_W   = 32,
  parameter logic [DATA_W-1:0]  PATTERN  = 32'h0000DEAD,
  parameter int                 ERR_W    = 8
) (
  input  logic              clock,
  input  logic              ctrl_reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  error_count,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic              first_fail_port,
  regfile_bist_if.master    rf
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  // Value a healthy register file returns: register 0 is hardwired to zero.
  function automatic logic [DATA_W-1:0] expected_word(input logic [ADDR_W-1:0] idx,
                                                       input logic inv);
    logic [DATA_W-1:0] w;
    if (idx == {ADDR_W{1'b0}}) begin
      w = {DATA_W{1'b0}};
    end else if (inv) begin
      w = ~PATTERN;
    end else begin
      w = PATTERN;
    end
    return w;
  endfunction

  // Saturating add of up to two mismatch flags onto the error counter.
  function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] cnt,
                                               input logic a, input logic b);
    logic [ERR_W+1:0] sum;
    logic [ERR_W-1:0] res;
    sum = {2'b00, cnt} + {{(ERR_W+1){1'b0}}, a} + {{(ERR_W+1){1'b0}}, b};
    if (sum > {2'b00, {ERR_W{1'b1}}}) begin
      res = {ERR_W{1'b1}};
    end else begin
      res = sum[ERR_W-1:0];
    end
    return res;
  endfunction

  state_t            state_q, state_d;
  logic              start_q, start_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              inv_q, inv_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [ADDR_W-1:0] ffa_q, ffa_d;
  logic              ffp_q, ffp_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] rrega_q, rrega_d;
  logic [ADDR_W-1:0] rregb_q, rregb_d;

  logic [DATA_W-1:0] exp_s;
  logic              mis_a_s;
  logic              mis_b_s;
  logic              finish_s;

  // Next-state and next-output computation for the BIST sequencer.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    inv_d    = inv_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    ffa_d    = ffa_q;
    ffp_d    = ffp_q;
    wen_d    = wen_q;
    wreg_d   = wreg_q;
    wdata_d  = wdata_q;
    rrega_d  = rrega_q;
    rregb_d  = rregb_q;
    mis_a_s  = 1'b0;
    mis_b_s  = 1'b0;
    finish_s = 1'b0;
    exp_s    = expected_word(idx_q, inv_q);

    // start is only captured while idle or done; it is acted on one cycle later.
    if ((state_q == S_IDLE) || (state_q == S_DONE)) begin
      start_d = start;
    end else begin
      start_d = 1'b0;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_q) begin
          state_d = S_WRITE;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = {ERR_W{1'b0}};
          ffa_d   = {ADDR_W{1'b0}};
          ffp_d   = 1'b0;
          idx_d   = {ADDR_W{1'b0}};
          inv_d   = 1'b0;
          wen_d   = 1'b1;
          wreg_d  = {ADDR_W{1'b0}};
          wdata_d = PATTERN;
        end else begin
          wen_d = 1'b0;
        end
      end
      S_WRITE: begin
        state_d = S_READ;
        wen_d   = 1'b0;
        rrega_d = idx_q;
        rregb_d = idx_q;
      end
      S_READ: begin
        state_d = S_CHECK;
        wen_d   = 1'b0;
      end
      S_CHECK: begin
        wen_d   = 1'b0;
        mis_a_s = (rf.rf_readDataA != exp_s);
        mis_b_s = (rf.rf_readDataB != exp_s);
        err_d   = sat_add(err_q, mis_a_s, mis_b_s);
        // First mismatch of the run wins; port A has priority on a tie.
        if ((mis_a_s || mis_b_s) && (err_q == {ERR_W{1'b0}})) begin
          ffa_d = idx_q;
          ffp_d = ~mis_a_s;
        end else begin
          ffa_d = ffa_q;
          ffp_d = ffp_q;
        end
        if (idx_q == LAST_IDX) begin
`ifdef REGFILE_BIST_INV_PASS_EN
          if (!inv_q) begin
            inv_d   = 1'b1;
            idx_d   = {ADDR_W{1'b0}};
            state_d = S_WRITE;
            wen_d   = 1'b1;
            wreg_d  = {ADDR_W{1'b0}};
            wdata_d = ~PATTERN;
          end else begin
            finish_s = 1'b1;
          end
`else
          finish_s = 1'b1;
`endif
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_WRITE;
          wen_d   = 1'b1;
          wreg_d  = idx_q + 1'b1;
          wdata_d = inv_q ? ~PATTERN : PATTERN;
        end
        if (finish_s) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == {ERR_W{1'b0}});
        end else begin
          done_d = done_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        wen_d   = 1'b0;
      end
    endcase
  end

  // State and registered-output flops; reset aborts any in-flight write at once.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      idx_q   <= {ADDR_W{1'b0}};
      inv_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= {ERR_W{1'b0}};
      ffa_q   <= {ADDR_W{1'b0}};
      ffp_q   <= 1'b0;
      wen_q   <= 1'b0;
      wreg_q  <= {ADDR_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
      rrega_q <= {ADDR_W{1'b0}};
      rregb_q <= {ADDR_W{1'b0}};
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      idx_q   <= idx_d;
      inv_q   <= inv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ffa_q   <= ffa_d;
      ffp_q   <= ffp_d;
      wen_q   <= wen_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      rrega_q <= rrega_d;
      rregb_q <= rregb_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign error_count     = err_q;
  assign first_fail_addr = ffa_q;
  assign first_fail_port = ffp_q;
  assign rf.rf_writeEn   = wen_q;
  assign rf.rf_writeReg  = wreg_q;
  assign rf.rf_writeData = wdata_q;
  assign rf.rf_readRegA  = rrega_q;
  assign rf.rf_readRegB  = rregb_q;

endmodule

// File: tb/tb_regfile_bist.sv
// Self-checking bench for regfile_bist: behavioural register file with
// injectable faults, write-sequence and end-of-run scoreboards.
module tb_regfile_bist;

  localparam logic [31:0] PAT = 32'h0000DEAD;
`ifdef REGFILE_BIST_INV_PASS_EN
  localparam int NP = 2;
`else
  localparam int NP = 1;
`endif

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    int         err;
    logic [4:0] ffa;
    logic       ffp;
    logic       ok;
    int         lat;
  } res_t;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, pass_o, ffp_o;
  logic [7:0]  err_o;
  logic [4:0]  ffa_o;
  logic [31:0] mem [32];
  int          fault_mode = 0;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  wr_t         wq[$];
  res_t        rq[$];
  wr_t         mon_w;

  regfile_bist_if rf_if ();

  regfile_bist dut (
    .clock           (clock),
    .ctrl_reset_n    (rst_n),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .pass            (pass_o),
    .error_count     (err_o),
    .first_fail_addr (ffa_o),
    .first_fail_port (ffp_o),
    .rf              (rf_if)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural register file with fault injection.
  function automatic logic [31:0] model_read(input logic [4:0] a);
    logic [31:0] v;
    v = mem[a];
    if (a == 5'd0 && fault_mode != 2) v = 32'd0;
    if (fault_mode == 1 && a == 5'd5) v[0] = 1'b0;
    if (fault_mode == 3 && a == 5'd3) v[31] = 1'b1;
    return v;
  endfunction

  always @(posedge clock) if (rf_if.rf_writeEn) mem[rf_if.rf_writeReg] <= rf_if.rf_writeData;
  always_comb rf_if.rf_readDataA = model_read(rf_if.rf_readRegA);
  always_comb rf_if.rf_readDataB = model_read(rf_if.rf_readRegB);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Write monitor: each observed write must match the next expected write.
  always @(negedge clock) begin
    if (rst_n && rf_if.rf_writeEn) begin
      if (wq.size() == 0) begin
        check_eq("wr_extra", 32'd1, 32'd0);
      end else begin
        mon_w = wq.pop_front();
        check_eq("wr_addr", {27'd0, rf_if.rf_writeReg}, {27'd0, mon_w.a});
        check_eq("wr_data", rf_if.rf_writeData, mon_w.d);
      end
    end
  end

  // Push expected writes and the expected end-of-run result for a fault mode.
  task automatic push_expect(input int fault);
    res_t        r;
    wr_t         w;
    logic [31:0] wd, stored, expv;
    r.err = 0; r.ffa = 5'd0; r.ffp = 1'b0;
    for (int p = 0; p < NP; p++) begin
      wd = (p == 0) ? PAT : ~PAT;
      for (int a = 0; a < 32; a++) begin
        w.a = a[4:0]; w.d = wd;
        wq.push_back(w);
        stored = (a == 0 && fault != 2) ? 32'd0 : wd;
        if (fault == 1 && a == 5) stored[0] = 1'b0;
        if (fault == 3 && a == 3) stored[31] = 1'b1;
        expv = (a == 0) ? 32'd0 : wd;
        if (stored != expv) begin
          if (r.err == 0) begin r.ffa = a[4:0]; r.ffp = 1'b0; end
          r.err = (r.err + 2 > 255) ? 255 : r.err + 2;
        end
      end
    end
    r.ok  = (r.err == 0);
    r.lat = 3 * 32 * NP + 1;
    rq.push_back(r);
  endtask

  // One run. mode 0: plain, 1: re-pulse start at index 10, 2: reset at index 10.
  task automatic run_test(input int fault, input int mode);
    res_t r;
    int   start_cyc, nbusy;
    bit   seen, pulsed, aborted;
    fault_mode = fault;
    push_expect(fault);
    @(negedge clock);
    start = 1'b1;
    start_cyc = cyc + 1;
    @(negedge clock);
    start = 1'b0;
    check_eq("busy_after_sample", {31'd0, busy}, 32'd0);
    nbusy = 0; seen = 0; pulsed = 0; aborted = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      start = 1'b0;
      if (done && !busy) begin seen = 1; break; end
      if (busy) nbusy++;
      if (busy && rf_if.rf_writeEn && rf_if.rf_writeReg == 5'd10 && !pulsed) begin
        pulsed = 1;
        if (mode == 1) begin
          start = 1'b1;
        end else if (mode == 2) begin
          #2 rst_n = 1'b0;
          #1;
          check_eq("rst_wen", {31'd0, rf_if.rf_writeEn}, 32'd0);
          check_eq("rst_busy", {31'd0, busy}, 32'd0);
          check_eq("rst_outs", {18'd0, done, pass_o, err_o, ffa_o, ffp_o}, 32'd0);
          check_eq("rst_waddr", {27'd0, rf_if.rf_writeReg}, 32'd0);
          wq.delete();
          r = rq.pop_back();
          @(negedge clock);
          rst_n = 1'b1;
          aborted = 1;
          break;
        end
      end
    end
    if (aborted) return;
    if (!seen) begin
      check_eq("timeout", 32'd0, 32'd1);
      return;
    end
    r = rq.pop_front();
    check_eq("latency", cyc - start_cyc, r.lat);
    check_eq("busy_cycles", nbusy, r.lat - 1);
    check_eq("error_count", {24'd0, err_o}, r.err);
    check_eq("first_fail_addr", {27'd0, ffa_o}, {27'd0, r.ffa});
    check_eq("first_fail_port", {31'd0, ffp_o}, {31'd0, r.ffp});
    check_eq("pass", {31'd0, pass_o}, {31'd0, r.ok});
    check_eq("wr_left", wq.size(), 32'd0);
    repeat (3) @(negedge clock);
    check_eq("done_held", {31'd0, done}, 32'd1);
    check_eq("wen_idle", {31'd0, rf_if.rf_writeEn}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    repeat (3) @(negedge clock);
    check_eq("reset_busy", {31'd0, busy}, 32'd0);
    check_eq("reset_outs", {18'd0, done, pass_o, err_o, ffa_o, ffp_o}, 32'd0);
    check_eq("reset_wen", {31'd0, rf_if.rf_writeEn}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clock);
    check_eq("idle_busy", {31'd0, busy}, 32'd0);

    run_test(0, 0);   // clean register file
    run_test(1, 0);   // reg 5 bit 0 stuck-at-0
    run_test(2, 0);   // reg 0 writable
    run_test(0, 1);   // start re-pulsed mid-run is ignored
    run_test(0, 2);   // reset during write of index 10
    run_test(0, 0);   // clean run after abort
    run_test(3, 0);   // reg 3 bit 31 stuck-at-1

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
